// File: rtl/vc_drop_ctrl.sv
// Squash-drop controller: counts outstanding memory requests, marks them stale on a
// squash and holds drop high until that many responses are consumed; throttles issue.
module vc_drop_ctrl #(
  parameter int p_max_inflight = 2,
  localparam int c_cnt_nbits = $clog2(p_max_inflight + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_go,
  input  logic                   resp_go,
  input  logic                   squash,
  output logic                   req_en,
  output logic                   drop,
  output logic [c_cnt_nbits-1:0] inflight,
  output logic [c_cnt_nbits-1:0] drop_cnt,
  output logic [1:0]             state,
  output logic                   err
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_busy  = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;

  localparam logic [c_cnt_nbits-1:0] c_zero = '0;
  localparam logic [c_cnt_nbits-1:0] c_one  = c_cnt_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] c_max  = c_cnt_nbits'(p_max_inflight);

  logic [c_cnt_nbits-1:0] inflight_q, inflight_d;
  logic [c_cnt_nbits-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]             state_q, state_d;
  logic                   err_q, err_d;
  logic                   req_ok, resp_ok;

  assign req_en = (inflight_q < c_max);
  assign drop   = (drop_cnt_q != c_zero) || (squash && (inflight_q != c_zero));

  // Illegal handshakes are ignored by the counters so they saturate instead of wrapping.
  assign req_ok  = req_go && req_en;
  assign resp_ok = resp_go && (inflight_q != c_zero);

  always_comb begin
    inflight_d = inflight_q;
    if (req_ok && !resp_ok) begin
      inflight_d = inflight_q + c_one;
    end else if (resp_ok && !req_ok) begin
      inflight_d = inflight_q - c_one;
    end
  end

  // A request issued in the squash cycle is the redirect fetch, so it is not counted stale.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (squash) begin
      drop_cnt_d = inflight_q - (resp_ok ? c_one : c_zero);
    end else if (resp_ok && (drop_cnt_q != c_zero)) begin
      drop_cnt_d = drop_cnt_q - c_one;
    end
  end

  always_comb begin
    err_d = err_q || (resp_go && (inflight_q == c_zero)) || (req_go && !req_en);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle, c_busy: begin
        if (inflight_d == c_zero)      state_d = c_idle;
        else if (drop_cnt_d != c_zero) state_d = c_drain;
        else                           state_d = c_busy;
      end
      c_drain: begin
        if (drop_cnt_d == c_zero) state_d = (inflight_d == c_zero) ? c_idle : c_busy;
        else                      state_d = c_drain;
      end
      default: state_d = c_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= c_zero;
      drop_cnt_q <= c_zero;
      state_q    <= c_idle;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign drop_cnt = drop_cnt_q;
  assign state    = state_q;
  assign err      = err_q;

endmodule

// File: tb/tb_vc_drop_ctrl.sv
// Bench for vc_drop_ctrl: directed scenarios plus random traffic against a queue model
// where each outstanding response carries a stale tag.
module tb_vc_drop_ctrl;
  localparam int MAX = 2;
  localparam int NB  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0, req_go = 1'b0, resp_go = 1'b0, squash = 1'b0;
  logic          req_en, drop, err;
  logic [NB-1:0] inflight, drop_cnt;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  int   mq[$];
  int   m_err;
  logic p_drop, p_req_en;
  int   e_drop, e_req_en;

  vc_drop_ctrl #(.p_max_inflight(MAX)) dut (
    .clk(clk), .reset(reset), .req_go(req_go), .resp_go(resp_go), .squash(squash),
    .req_en(req_en), .drop(drop), .inflight(inflight), .drop_cnt(drop_cnt),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int m_stale();
    int n = 0;
    foreach (mq[i]) n += mq[i];
    return n;
  endfunction

  function automatic int m_state();
    if (m_stale() > 0) return 2;
    if (mq.size() > 0) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_go = 1'b0; resp_go = 1'b0; squash = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    m_err = 0;
    #1;
  endtask

  // One cycle of stimulus; records the combinational outputs seen during it and advances the model.
  task automatic drive(input logic rq, input logic rs, input logic sq);
    int sz;
    @(negedge clk);
    req_go = rq; resp_go = rs; squash = sq;
    #1;
    p_drop = drop; p_req_en = req_en;
    sz = mq.size();
    e_drop = ((m_stale() > 0) || (sq && sz > 0)) ? 1 : 0;
    e_req_en = (sz < MAX) ? 1 : 0;
    if (rs) begin
      if (sz == 0) m_err = 1;
      else void'(mq.pop_front());
    end
    if (sq) foreach (mq[i]) mq[i] = 1;
    if (rq) begin
      if (sz < MAX) mq.push_back(0);
      else m_err = 1;
    end
    @(posedge clk); #1;
    req_go = 1'b0; resp_go = 1'b0; squash = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inflight !== 0) begin errors++; $display("FAIL rst_inflight got %0d want 0", inflight); end
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
    checks++; if (state !== 0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (req_en !== 1'b1) begin errors++; $display("FAIL rst_req_en got %b want 1", req_en); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", drop); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    drive(1, 0, 0);
    checks++; if (inflight !== 1) begin errors++; $display("FAIL fill_inflight1 got %0d want 1", inflight); end
    checks++; if (state !== 1) begin errors++; $display("FAIL fill_busy got %0d want 1", state); end
    drive(1, 0, 0);
    checks++; if (inflight !== 2) begin errors++; $display("FAIL fill_inflight2 got %0d want 2", inflight); end
    checks++; if (req_en !== 1'b0) begin errors++; $display("FAIL fill_req_en_full got %b want 0", req_en); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b0) begin errors++; $display("FAIL fill_drop_r1 got %b want 0", p_drop); end
    checks++; if (req_en !== 1'b1) begin errors++; $display("FAIL fill_req_en_back got %b want 1", req_en); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b0) begin errors++; $display("FAIL fill_drop_r2 got %b want 0", p_drop); end
    checks++; if (state !== 0 || inflight !== 0) begin errors++; $display("FAIL fill_idle got state %0d inflight %0d want 0 0", state, inflight); end
  endtask

  task automatic test_squash();
    do_reset();
    drive(1, 0, 0); drive(1, 0, 0);
    drive(0, 0, 1);
    checks++; if (p_drop !== 1'b1) begin errors++; $display("FAIL sq_drop_same got %b want 1", p_drop); end
    checks++; if (drop_cnt !== 2 || state !== 2) begin errors++; $display("FAIL sq_load got cnt %0d state %0d want 2 2", drop_cnt, state); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b1 || drop_cnt !== 1) begin errors++; $display("FAIL sq_r1 got drop %b cnt %0d want 1 1", p_drop, drop_cnt); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b1 || drop_cnt !== 0) begin errors++; $display("FAIL sq_r2 got drop %b cnt %0d want 1 0", p_drop, drop_cnt); end
    checks++; if (drop !== 1'b0 || state !== 0) begin errors++; $display("FAIL sq_done got drop %b state %0d want 0 0", drop, state); end
  endtask

  task automatic test_squash_resp();
    do_reset();
    drive(1, 0, 0); drive(1, 0, 0);
    drive(0, 1, 1);
    checks++; if (p_drop !== 1'b1) begin errors++; $display("FAIL sqr_drop got %b want 1", p_drop); end
    checks++; if (drop_cnt !== 1 || inflight !== 1) begin errors++; $display("FAIL sqr_cnt got cnt %0d inflight %0d want 1 1", drop_cnt, inflight); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b1 || state !== 0) begin errors++; $display("FAIL sqr_end got drop %b state %0d want 1 0", p_drop, state); end
  endtask

  task automatic test_squash_req();
    do_reset();
    drive(1, 0, 0);
    drive(1, 0, 1);
    checks++; if (drop_cnt !== 1 || inflight !== 2) begin errors++; $display("FAIL sqq_cnt got cnt %0d inflight %0d want 1 2", drop_cnt, inflight); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b1 || state !== 1) begin errors++; $display("FAIL sqq_first got drop %b state %0d want 1 1", p_drop, state); end
    drive(0, 1, 0);
    checks++; if (p_drop !== 1'b0 || state !== 0) begin errors++; $display("FAIL sqq_second got drop %b state %0d want 0 0", p_drop, state); end
  endtask

  task automatic test_resquash_reset();
    do_reset();
    drive(1, 0, 0); drive(1, 0, 0); drive(0, 0, 1); drive(0, 1, 0); drive(1, 0, 0);
    checks++; if (drop_cnt !== 1 || inflight !== 2 || state !== 2) begin errors++; $display("FAIL rsq_pre got cnt %0d inflight %0d state %0d want 1 2 2", drop_cnt, inflight, state); end
    drive(0, 0, 1);
    checks++; if (drop_cnt !== 2 || state !== 2) begin errors++; $display("FAIL rsq_reload got cnt %0d state %0d want 2 2", drop_cnt, state); end
    do_reset();
    checks++; if (drop_cnt !== 0 || inflight !== 0 || state !== 0) begin errors++; $display("FAIL rsq_reset got cnt %0d inflight %0d state %0d want 0 0 0", drop_cnt, inflight, state); end
    checks++; if (drop !== 1'b0 || req_en !== 1'b1) begin errors++; $display("FAIL rsq_outs got drop %b req_en %b want 0 1", drop, req_en); end
  endtask

  task automatic test_errors();
    do_reset();
    drive(0, 1, 0);
    checks++; if (err !== 1'b1 || inflight !== 0) begin errors++; $display("FAIL err_resp got err %b inflight %0d want 1 0", err, inflight); end
    drive(1, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
    checks++; if (err !== 1'b1 || inflight !== 2) begin errors++; $display("FAIL err_req got err %b inflight %0d want 1 2", err, inflight); end
  endtask

  task automatic test_random();
    logic rq, rs, sq;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        rq = ($urandom_range(0, 9) < 5) && (mq.size() < MAX || $urandom_range(0, 19) == 0);
        rs = ($urandom_range(0, 9) < 5) && (mq.size() > 0 || $urandom_range(0, 19) == 0);
        sq = ($urandom_range(0, 9) == 0);
        drive(rq, rs, sq);
        checks++; if (p_drop !== e_drop[0]) begin errors++; $display("FAIL rnd_drop cyc %0d got %b want %0d", n, p_drop, e_drop); end
        checks++; if (p_req_en !== e_req_en[0]) begin errors++; $display("FAIL rnd_req_en cyc %0d got %b want %0d", n, p_req_en, e_req_en); end
      end
      checks++; if (inflight !== mq.size()) begin errors++; $display("FAIL rnd_inflight cyc %0d got %0d want %0d", n, inflight, mq.size()); end
      checks++; if (drop_cnt !== m_stale()) begin errors++; $display("FAIL rnd_drop_cnt cyc %0d got %0d want %0d", n, drop_cnt, m_stale()); end
      checks++; if (state !== m_state()) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", n, state, m_state()); end
      checks++; if (err !== m_err[0]) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %0d", n, err, m_err); end
    end
  endtask

  initial begin
    m_err = 0;
    test_reset();
    test_fill_drain();
    test_squash();
    test_squash_resp();
    test_squash_req();
    test_resquash_reset();
    test_errors();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
